// File: rtl/dpram_be.sv
// Simple dual-port RAM with per-lane write enables, 1- or 2-cycle read latency
// and optional same-edge write-to-read forwarding.
module dpram_be #(
    parameter int unsigned numwords     = 256,
    parameter int unsigned widthad      = 8,
    parameter int unsigned width        = 32,
    parameter int unsigned byte_width   = 8,
    parameter int unsigned read_latency = 1,
    parameter int unsigned bypass       = 1
) (
    input  logic                          clock_in,
    input  logic                          reset_in,
    input  logic [widthad-1:0]            address_a,
    input  logic [width-1:0]              data_a,
    input  logic [width/byte_width-1:0]   byteena_a,
    input  logic                          wren_a,
    input  logic [widthad-1:0]            address_b,
    input  logic                          rden_b,
    output logic [width-1:0]              q_b,
    output logic                          q_valid_b
);

    localparam int unsigned LANES = width / byte_width;
    localparam int unsigned AW1   = widthad + 1;
    localparam logic [AW1-1:0] NUM_W = AW1'(numwords);

    logic [width-1:0] mem_q [numwords];

    logic             wr_in_range_c;
    logic             rd_in_range_c;
    logic             wr_en_c;
    logic             rd_en_c;
    logic             collide_c;
    logic [width-1:0] old_word_c;
    logic [width-1:0] rd_word_c;

    logic             pipe_valid_c;
    logic [width-1:0] pipe_data_c;

    logic [width-1:0] q_data_q, q_data_d;
    logic             q_valid_q, q_valid_d;

    // Request qualification and collision detect
    always_comb begin
        wr_in_range_c = ({1'b0, address_a} < NUM_W);
        rd_in_range_c = ({1'b0, address_b} < NUM_W);
        wr_en_c       = reset_in && wren_a && wr_in_range_c && (|byteena_a);
        rd_en_c       = reset_in && rden_b;
        collide_c     = wr_en_c && rd_in_range_c && (address_a == address_b);
        old_word_c    = '0;
        if (rd_in_range_c) begin
            old_word_c = mem_q[address_b];
        end
    end

    // Enabled lanes of a colliding write are forwarded when bypass is on
    always_comb begin
        rd_word_c = old_word_c;
        if ((bypass != 0) && collide_c) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (byteena_a[i]) begin
                    rd_word_c[i*byte_width +: byte_width] = data_a[i*byte_width +: byte_width];
                end
            end
        end
    end

    // Memory array is intentionally left out of reset
    always_ff @(posedge clock_in) begin
        if (wr_en_c) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (byteena_a[i]) begin
                    mem_q[address_a][i*byte_width +: byte_width] <= data_a[i*byte_width +: byte_width];
                end
            end
        end
    end

    generate
        if (read_latency == 2) begin : g_lat2
            logic [width-1:0] s1_data_q, s1_data_d;
            logic             s1_valid_q, s1_valid_d;

            // Data is captured at the accept edge so later writes cannot disturb it
            always_comb begin
                s1_valid_d = rd_en_c;
                s1_data_d  = rd_en_c ? rd_word_c : s1_data_q;
            end

            always_ff @(posedge clock_in) begin
                if (!reset_in) begin
                    s1_valid_q <= 1'b0;
                    s1_data_q  <= '0;
                end else begin
                    s1_valid_q <= s1_valid_d;
                    s1_data_q  <= s1_data_d;
                end
            end

            assign pipe_valid_c = s1_valid_q;
            assign pipe_data_c  = s1_data_q;
        end else begin : g_lat1
            assign pipe_valid_c = rd_en_c;
            assign pipe_data_c  = rd_word_c;
        end
    endgenerate

    // Output stage holds q_b between valid reads
    always_comb begin
        q_valid_d = pipe_valid_c;
        q_data_d  = pipe_valid_c ? pipe_data_c : q_data_q;
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            q_valid_q <= 1'b0;
            q_data_q  <= '0;
        end else begin
            q_valid_q <= q_valid_d;
            q_data_q  <= q_data_d;
        end
    end

    assign q_b       = q_data_q;
    assign q_valid_b = q_valid_q;

endmodule

// File: tb/tb_dpram_be.sv
// Scoreboard bench: two dpram_be instances (lat1/bypass/256 words and
// lat2/no-bypass/200 words) share stimulus; a reference model predicts reads.
module tb_dpram_be;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        reset_in;
    logic [7:0]  address_a;
    logic [31:0] data_a;
    logic [3:0]  byteena_a;
    logic        wren_a;
    logic [7:0]  address_b;
    logic        rden_b;
    logic [31:0] q0, q1;
    logic        v0, v1;

    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic        rst_edge = 1'b1;
    logic [31:0] m0 [256];
    logic [31:0] m1 [200];
    logic [31:0] last0 = '0;
    logic [31:0] last1 = '0;
    exp_t        sb0 [$];
    exp_t        sb1 [$];

    dpram_be u_dut0 (
        .clock_in(clk), .reset_in(reset_in),
        .address_a(address_a), .data_a(data_a), .byteena_a(byteena_a), .wren_a(wren_a),
        .address_b(address_b), .rden_b(rden_b), .q_b(q0), .q_valid_b(v0)
    );

    dpram_be #(.numwords(200), .read_latency(2), .bypass(0)) u_dut1 (
        .clock_in(clk), .reset_in(reset_in),
        .address_a(address_a), .data_a(data_a), .byteena_a(byteena_a), .wren_a(wren_a),
        .address_b(address_b), .rden_b(rden_b), .q_b(q1), .q_valid_b(v1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= !reset_in;
    end

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, id, cyc, act, exp);
        end
    endtask

    // Reference read: word content seen by a read at this edge
    function automatic logic [31:0] model_rd(input int id, input logic wr, input logic [7:0] aa,
                                             input logic [31:0] da, input logic [3:0] be,
                                             input logic [7:0] ab);
        int          nw;
        logic [31:0] r;
        nw = (id == 0) ? 256 : 200;
        if (int'(ab) >= nw) return 32'h0;
        r = (id == 0) ? m0[ab] : m1[ab];
        if (id == 0 && wr && aa == ab)
            for (int i = 0; i < 4; i++)
                if (be[i]) r[i*8 +: 8] = da[i*8 +: 8];
        return r;
    endfunction

    task automatic model_wr(input logic [7:0] aa, input logic [31:0] da, input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                m0[aa][i*8 +: 8] = da[i*8 +: 8];
                if (int'(aa) < 200) m1[aa][i*8 +: 8] = da[i*8 +: 8];
            end
        end
    endtask

    task automatic drive(input logic rst_n, input logic wr, input logic [7:0] aa, input logic [31:0] da,
                         input logic [3:0] be, input logic rd, input logic [7:0] ab);
        exp_t e;
        @(negedge clk);
        reset_in  = rst_n;
        wren_a    = wr;
        address_a = aa;
        data_a    = da;
        byteena_a = be;
        rden_b    = rd;
        address_b = ab;
        if (!rst_n) begin
            // Anything that would surface at or after the reset edge is lost
            while (sb0.size() > 0 && sb0[$].due > cyc) void'(sb0.pop_back());
            while (sb1.size() > 0 && sb1[$].due > cyc) void'(sb1.pop_back());
        end else begin
            if (rd) begin
                e.data = model_rd(0, wr, aa, da, be, ab); e.due = cyc + 1; sb0.push_back(e);
                e.data = model_rd(1, wr, aa, da, be, ab); e.due = cyc + 2; sb1.push_back(e);
            end
            if (wr) model_wr(aa, da, be);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
    endtask

    task automatic mon(input int id, input logic v, input logic [31:0] q);
        exp_t        e;
        logic [31:0] held;
        int          sz;
        held = (id == 0) ? last0 : last1;
        sz   = (id == 0) ? sb0.size() : sb1.size();
        if (rst_edge) begin
            chk("reset_q", id, q, 32'h0);
            chk("reset_valid", id, {31'd0, v}, 32'h0);
            if (id == 0) last0 = '0; else last1 = '0;
        end else if (v) begin
            if (sz == 0) begin
                chk("spurious_valid", id, 32'd1, 32'd0);
            end else begin
                e = (id == 0) ? sb0.pop_front() : sb1.pop_front();
                chk("read_data", id, q, e.data);
                chk("read_latency", id, 32'(cyc), 32'(e.due));
                if (id == 0) last0 = e.data; else last1 = e.data;
            end
        end else begin
            chk("hold_q", id, q, held);
            if (sz > 0) begin
                e = (id == 0) ? sb0[0] : sb1[0];
                if (e.due <= cyc) begin
                    chk("missing_valid", id, 32'(cyc), 32'(e.due));
                    if (id == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            mon(0, v0, q0);
            mon(1, v1, q1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: timeout at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] aa, ab;
        reset_in = 1'b0; wren_a = 1'b0; rden_b = 1'b0;
        address_a = '0; address_b = '0; data_a = '0; byteena_a = '0;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'd3, 32'h1, 4'hf, 1'b1, 8'd3);
        // Preload every word so the model knows the whole array
        for (int a = 0; a < 256; a++) drive(1'b1, 1'b1, 8'(a), $urandom, 4'hf, 1'b0, 8'd0);
        // Full and partial lane writes
        drive(1'b1, 1'b1, 8'd5, 32'hDEADBEEF, 4'b1111, 1'b0, 8'd0);
        drive(1'b1, 1'b0, 8'd0, 32'h0, 4'b0000, 1'b1, 8'd5);
        drive(1'b1, 1'b1, 8'd5, 32'h11223344, 4'b0101, 1'b0, 8'd0);
        drive(1'b1, 1'b0, 8'd0, 32'h0, 4'b0000, 1'b1, 8'd5);
        // Same-edge collision
        drive(1'b1, 1'b1, 8'd7, 32'hAAAAAAAA, 4'b1111, 1'b0, 8'd0);
        drive(1'b1, 1'b1, 8'd7, 32'h55555555, 4'b0011, 1'b1, 8'd7);
        drive(1'b1, 1'b0, 8'd0, 32'h0, 4'b0000, 1'b1, 8'd7);
        // Zero byteena leaves memory alone
        drive(1'b1, 1'b1, 8'd7, 32'h12345678, 4'b0000, 1'b1, 8'd7);
        idle(3);
        // Back-to-back burst
        for (int a = 0; a < 8; a++) drive(1'b1, 1'b1, 8'(a), 32'(a), 4'hf, 1'b0, 8'd0);
        for (int a = 0; a < 8; a++) drive(1'b1, 1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'(a));
        idle(3);
        // Reset the edge after a read
        drive(1'b1, 1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd5);
        drive(1'b0, 1'b1, 8'd5, 32'hFFFFFFFF, 4'hf, 1'b1, 8'd5);
        idle(3);
        drive(1'b1, 1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd5);
        idle(3);
        // Out-of-range on the 200-word instance, last valid word
        drive(1'b1, 1'b1, 8'd220, 32'h00001234, 4'hf, 1'b0, 8'd0);
        drive(1'b1, 1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd220);
        drive(1'b1, 1'b1, 8'd199, 32'hCAFEF00D, 4'hf, 1'b0, 8'd0);
        drive(1'b1, 1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd199);
        // Write one edge after a read of the same word
        drive(1'b1, 1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd9);
        drive(1'b1, 1'b1, 8'd9, 32'h0BADCAFE, 4'hf, 1'b1, 8'd9);
        idle(3);
        // Randomised traffic biased toward collisions and the range boundary
        for (int n = 0; n < 3000; n++) begin
            aa = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255)) : 8'($urandom_range(0, 15));
            ab = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255)) : 8'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) ab = aa;
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 1) == 1), aa, $urandom,
                  4'($urandom), ($urandom_range(0, 3) != 0), ab);
        end
        idle(6);
        chk("drain", 0, 32'(sb0.size()), 32'd0);
        chk("drain", 1, 32'(sb1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
